// File: rtl/multu_if.sv
// multu operand/result bundle
// start/busy/done handshake shared with the divider
interface multu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output a, b, sign, start,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, sign, start,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/multu.sv
// Iterative 32x32 shift-add multiplier
// 33-cycle latency, state on negedge clock
module multu (
  input  logic    clock,
  input  logic    reset,
  multu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_q,   acc_d;
  logic [31:0] mpl_q,   mpl_d;
  logic        neg_q,   neg_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [32:0] sum;
  logic [63:0] prod;
  logic [63:0] res;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign a_mag = (bus.sign & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = (bus.sign & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  assign sum  = {1'b0, acc_q}
              + {1'b0, (mpl_q[0] ? mcand_q : 32'd0)};
  assign prod = {acc_q, mpl_q};
  assign res  = neg_q ? (~prod + 64'd1) : prod;

  // Next-state: start restarts from any state, else step the FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mpl_d   = mpl_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (bus.start) begin
      state_d = RUN;
      count_d = 5'd0;
      mcand_d = a_mag;
      mpl_d   = b_mag;
      acc_d   = 32'd0;
      neg_d   = bus.sign & (bus.a[31] ^ bus.b[31]);
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d = 1'b0;
        end
        RUN: begin
          acc_d   = sum[32:1];
          mpl_d   = {sum[0], mpl_q[31:1]};
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = FIX;
          end
        end
        FIX: begin
          hi_d    = res[63:32];
          lo_d    = res[31:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Registers on the falling edge with synchronous active-low reset
  always_ff @(negedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      mcand_q <= 32'd0;
      acc_q   <= 32'd0;
      mpl_q   <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_multu.sv
// Testbench for multu
// vector table plus directed restart/reset sequences
module tb_multu;

  logic clock;
  logic reset;
  multu_if bus ();

  multu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  int tests;
  int fails;
  logic [63:0] sb_q[$];
  vec_t vt[14];

  function automatic logic [63:0] model(
    logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // entered just after a posedge; returns after the posedge following E0
  task automatic issue(logic [31:0] a, logic [31:0] b, logic s);
    bus.a     = a;
    bus.b     = b;
    bus.sign  = s;
    bus.start = 1'b1;
    @(posedge clock);
    bus.start = 1'b0;
    chk("busy_rise", {63'd0, bus.busy}, 64'd1);
    chk("done_low_after_start", {63'd0, bus.done}, 64'd0);
  endtask

  task automatic finish_op(string nm);
    int bc;
    bit ok;
    logic [63:0] e;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      @(posedge clock);
    end
    chk({nm, "_timeout"}, {63'd0, ok}, 64'd1);
    if (ok) begin
      chk({nm, "_busy_cycles"}, 64'(bc), 64'd33);
      chk({nm, "_busy_fall"}, {63'd0, bus.busy}, 64'd0);
      if (sb_q.size() == 0) begin
        chk({nm, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk({nm, "_result"}, {bus.hi, bus.lo}, e);
      end
    end
  endtask

  initial begin
    logic [63:0] prev;
    int dn;
    tests = 0;
    fails = 0;
    bus.a = '0;
    bus.b = '0;
    bus.sign = 1'b0;
    bus.start = 1'b0;
    reset = 1'b0;

    vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vt[1] = '{32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1};
    vt[2] = '{32'hFFFFFFFD, 32'd5,        1'b0, 64'h00000004_FFFFFFF1};
    vt[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vt[4] = '{32'h80000000, 32'd1,        1'b1, 64'hFFFFFFFF_80000000};
    vt[5] = '{32'd0,        32'hFFFFFFFF, 1'b1, 64'd0};
    vt[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};
    for (int i = 8; i < 14; i++) begin
      vt[i].a = $urandom;
      vt[i].b = $urandom;
      vt[i].s = i[0];
      vt[i].p = model(vt[i].a, vt[i].b, vt[i].s);
    end

    repeat (2) @(posedge clock);
    reset = 1'b1;
    chk("reset_state", {bus.hi, bus.lo},  64'd0);
    chk("reset_busy",  {63'd0, bus.busy}, 64'd0);
    chk("reset_done",  {63'd0, bus.done}, 64'd0);
    repeat (3) @(posedge clock);
    chk("idle_busy",   {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 14; i++) begin
      sb_q.push_back(vt[i].p);
      issue(vt[i].a, vt[i].b, vt[i].s);
      finish_op($sformatf("vec%0d", i));
    end
    @(posedge clock);
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
    prev = {bus.hi, bus.lo};

    // restart mid-operation
    sb_q.push_back(64'd42);
    issue(32'd7, 32'd6, 1'b0);
    dn = 0;
    repeat (9) begin
      if (bus.done) dn++;
      @(posedge clock);
    end
    chk("restart_hold", {bus.hi, bus.lo}, prev);
    sb_q.delete();
    sb_q.push_back(64'h00000001_00000000);
    issue(32'h10000, 32'h10000, 1'b0);
    chk("restart_hold2", {bus.hi, bus.lo}, prev);
    chk("restart_no_done", 64'(dn), 64'd0);
    finish_op("restart");

    // reset mid-operation
    sb_q.push_back(64'd42);
    issue(32'd6, 32'd7, 1'b0);
    finish_op("pre42");
    sb_q.push_back(64'd9);
    issue(32'd3, 32'd3, 1'b0);
    repeat (14) @(posedge clock);
    reset = 1'b0;
    @(posedge clock);
    reset = 1'b1;
    sb_q.delete();
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    dn = 0;
    repeat (40) begin
      if (bus.done) dn++;
      @(posedge clock);
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    sb_q.push_back(64'd9);
    issue(32'd3, 32'd3, 1'b0);
    finish_op("after_rst");

    // reset coinciding with start
    reset = 1'b0;
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.start = 1'b1;
    @(posedge clock);
    reset = 1'b1;
    bus.start = 1'b0;
    chk("rst_start_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clock);
    chk("rst_start_idle", {63'd0, bus.busy}, 64'd0);

    // start held high never completes
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.sign = 1'b0;
    bus.start = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clock);
      if (bus.done) dn++;
    end
    chk("hold_no_done", 64'(dn), 64'd0);
    chk("hold_busy", {63'd0, bus.busy}, 64'd1);
    bus.start = 1'b0;
    sb_q.push_back(64'd6);
    finish_op("hold_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
